// File: rtl/seg_display_pkg.sv
// Shared constants and types for the four-digit 7-segment display controller.
package seg_display_pkg;

  // Segment and anode patterns for a dark digit (both active-low).
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // PRIME takes the first snapshot after reset; SCAN rotates digits forever.
  typedef enum logic {
    PRIME = 1'b0,
    SCAN  = 1'b1
  } state_e;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_seg7
  import seg_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for this nibble.
  always_comb begin
    seg = HEX_SEG[nib];
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Time-multiplexed four-digit hex display driver. The shown word is
// re-sampled once per full scan so a changing input never tears across digits.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned      DIV_W   = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      snap_q, snap_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic       tick;
  logic       lz_blank;
  logic [3:0] nib;
  logic [6:0] nib_seg;

  // Nibble of the snapshot belonging to the digit currently being scanned.
  assign nib = snap_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nib (nib),
    .seg (nib_seg)
  );

  // Decimal point is never lit.
  assign dp  = 1'b1;
  assign an  = an_q;
  assign seg = seg_q;

  // Next-state logic: divider, digit index, snapshot capture and output patterns.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    an_d      = an_q;
    seg_d     = seg_q;

    tick     = (div_cnt_q == DIV_MAX);
    // A digit above position 0 is dark when it and everything above it is zero.
    lz_blank = BLANK_LZ && (idx_q != 2'd0) && ((snap_q >> {idx_q, 2'b00}) == 16'h0000);

    case (state_q)
      PRIME: begin
        snap_d  = data_in;
        state_d = SCAN;
      end
      SCAN: begin
        if (tick) begin
          div_cnt_d = '0;
          idx_d     = idx_q + 2'd1;
          // Capture only at frame wrap so all four digits come from one word.
          if (idx_q == 2'd3) begin
            snap_d = data_in;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (blank || lz_blank) begin
          an_d  = AN_OFF;
          seg_d = SEG_OFF;
        end else begin
          an_d  = ~(4'b0001 << idx_q);
          seg_d = nib_seg;
        end
      end
      default: begin
        state_d = PRIME;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PRIME;
      div_cnt_q <= '0;
      idx_q     <= 2'd0;
      snap_q    <= 16'h0000;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

endmodule
